// File: rtl/touch_key_ctrl_if.sv
// Signal bundle between the touch decoder / sequencer and the fish-counter control path.
// The master drives the sample strobe and key hits; the slave returns the command and state outputs.
interface touch_key_ctrl_if;
    logic       sample_en;
    logic       op_cl_hit;
    logic       pl_pa_hit;
    logic       clear_hit;
    logic       gate_open;
    logic       run;
    logic       clear_pulse;
    logic       key_evt;
    logic [1:0] key_id;
    logic       busy;

    modport master (
        output sample_en, op_cl_hit, pl_pa_hit, clear_hit,
        input  gate_open, run, clear_pulse, key_evt, key_id, busy
    );

    modport slave (
        input  sample_en, op_cl_hit, pl_pa_hit, clear_hit,
        output gate_open, run, clear_pulse, key_evt, key_id, busy
    );
endinterface

// File: rtl/touch_key_ctrl.sv
// Debounced 3-key command sequencer: accepts a press after DEB_N matching samples,
// fires one command, then waits for REL_N empty samples before re-arming.
module touch_key_ctrl #(
    parameter int unsigned DEB_N = 4,
    parameter int unsigned REL_N = 4
) (
    input  logic             clk,
    input  logic             reset,
    touch_key_ctrl_if.slave  tk
);
    typedef enum logic [1:0] {StIdle, StDeb, StFire, StRel} state_e;

    localparam logic [7:0] DebLim = 8'(DEB_N);
    localparam logic [7:0] RelLim = 8'(REL_N);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0] cand_q, cand_d;
    logic [1:0] code;
    logic       gate_q, gate_d;
    logic       run_q, run_d;
    logic       clr_q, clr_d;
    logic       evt_q, evt_d;
    logic [1:0] id_q, id_d;

    // Zero or multiple simultaneous hits decode as "no key".
    always_comb begin
        code = 2'd0;
        unique case ({tk.op_cl_hit, tk.pl_pa_hit, tk.clear_hit})
            3'b100:  code = 2'd1;
            3'b010:  code = 2'd2;
            3'b001:  code = 2'd3;
            default: code = 2'd0;
        endcase
    end

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        gate_d  = gate_q;
        run_d   = run_q;
        clr_d   = 1'b0;
        evt_d   = 1'b0;
        id_d    = id_q;
        unique case (state_q)
            StIdle: begin
                if (tk.sample_en && code != 2'd0) begin
                    cand_d  = code;
                    cnt_d   = 8'd1;
                    state_d = (DebLim == 8'd1) ? StFire : StDeb;
                end
            end
            StDeb: begin
                if (tk.sample_en) begin
                    if (code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DebLim) state_d = StFire;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = StIdle;
                    end
                end
            end
            StFire: begin
                state_d = StRel;
                cnt_d   = 8'd0;
                evt_d   = 1'b1;
                id_d    = cand_q;
                unique case (cand_q)
                    2'd1: begin
                        gate_d = ~gate_q;
                        // Closing the gate always stops counting.
                        if (gate_q) run_d = 1'b0;
                    end
                    2'd2: begin
                        if (gate_q) run_d = ~run_q;
                    end
                    2'd3:    clr_d = 1'b1;
                    default: ;
                endcase
            end
            StRel: begin
                if (tk.sample_en) begin
                    if (code == 2'd0) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= RelLim) begin
                            cnt_d   = 8'd0;
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = 8'd0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            cand_q  <= 2'd0;
            gate_q  <= 1'b0;
            run_q   <= 1'b0;
            clr_q   <= 1'b0;
            evt_q   <= 1'b0;
            id_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            gate_q  <= gate_d;
            run_q   <= run_d;
            clr_q   <= clr_d;
            evt_q   <= evt_d;
            id_q    <= id_d;
        end
    end

    assign tk.gate_open   = gate_q;
    assign tk.run         = run_q;
    assign tk.clear_pulse = clr_q;
    assign tk.key_evt     = evt_q;
    assign tk.key_id      = id_q;
    assign tk.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_touch_key_ctrl.sv
// Bench for touch_key_ctrl: directed scenarios plus randomized key bursts,
// every clock compared against a streak-counting reference model.
module tb_touch_key_ctrl;
    localparam int unsigned DEB_N = 4;
    localparam int unsigned REL_N = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    touch_key_ctrl_if tk();

    touch_key_ctrl #(.DEB_N(DEB_N), .REL_N(REL_N)) dut (
        .clk   (clk),
        .reset (reset),
        .tk    (tk)
    );

    int n_checks = 0;
    int n_errors = 0;
    int dut_evts = 0;
    int dut_clrs = 0;

    // Reference model: armed/streak/quiet counters rather than explicit states.
    bit m_armed, m_fire, m_gate, m_run, m_evt, m_clr;
    int m_streak, m_quiet, m_cand, m_id;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int key_code(input bit o, input bit p, input bit c);
        if (int'(o) + int'(p) + int'(c) != 1) return 0;
        return o ? 1 : (p ? 2 : 3);
    endfunction

    task automatic model_reset();
        m_armed = 1; m_fire = 0; m_gate = 0; m_run = 0; m_evt = 0; m_clr = 0;
        m_streak = 0; m_quiet = 0; m_cand = 0; m_id = 0;
    endtask

    task automatic model_step();
        int c;
        m_evt = 0;
        m_clr = 0;
        if (m_fire) begin
            m_fire = 0; m_evt = 1; m_id = m_cand;
            if (m_cand == 1) begin
                if (m_gate) m_run = 0;
                m_gate = !m_gate;
            end else if (m_cand == 2) begin
                if (m_gate) m_run = !m_run;
            end else begin
                m_clr = 1;
            end
            m_armed = 0; m_quiet = 0; m_streak = 0;
        end else if (tk.sample_en) begin
            c = key_code(tk.op_cl_hit, tk.pl_pa_hit, tk.clear_hit);
            if (!m_armed) begin
                if (c == 0) begin
                    m_quiet++;
                    if (m_quiet >= int'(REL_N)) begin m_armed = 1; m_quiet = 0; end
                end else begin
                    m_quiet = 0;
                end
            end else if (m_streak == 0) begin
                if (c != 0) begin
                    m_cand = c; m_streak = 1; m_fire = (m_streak >= int'(DEB_N));
                end
            end else if (c == m_cand) begin
                m_streak++; m_fire = (m_streak >= int'(DEB_N));
            end else begin
                m_streak = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("gate_open", int'(tk.gate_open), int'(m_gate));
        check("run", int'(tk.run), int'(m_run));
        check("clear_pulse", int'(tk.clear_pulse), int'(m_clr));
        check("key_evt", int'(tk.key_evt), int'(m_evt));
        check("key_id", int'(tk.key_id), m_id);
        check("busy", int'(tk.busy), int'(!m_armed || m_streak != 0 || m_fire));
    endtask

    // Called just after a rising edge; drives inputs, clocks once, compares.
    task automatic cycle(input bit en, input bit o, input bit p, input bit c);
        tk.sample_en = en; tk.op_cl_hit = o; tk.pl_pa_hit = p; tk.clear_hit = c;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (tk.key_evt === 1'b1) dut_evts++;
        if (tk.clear_pulse === 1'b1) dut_clrs++;
    endtask

    task automatic hold(input int n, input bit en, input bit o, input bit p, input bit c);
        for (int i = 0; i < n; i++) cycle(en, o, p, c);
    endtask

    task automatic press(input bit o, input bit p, input bit c);
        hold(int'(DEB_N) + 1, 1, o, p, c);
        hold(int'(REL_N), 1, 0, 0, 0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_async_gate", int'(tk.gate_open), 0);
        check("rst_async_busy", int'(tk.busy), 0);
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int e0, c0, len, pat;
        bit en, o, p, c;
        tk.sample_en = 0; tk.op_cl_hit = 0; tk.pl_pa_hit = 0; tk.clear_hit = 0;
        model_reset();
        #1;
        compare_all();
        check("reset_key_id", int'(tk.key_id), 0);
        #11;
        reset = 1'b1;

        // 1: op_cl held long -> exactly one event, gate opens.
        e0 = dut_evts;
        hold(int'(DEB_N) + 20, 1, 1, 0, 0);
        check("s1_evts", dut_evts - e0, 1);
        check("s1_gate", int'(tk.gate_open), 1);
        check("s1_key_id", int'(tk.key_id), 1);
        hold(int'(REL_N), 1, 0, 0, 0);

        // 2: run toggles twice with gate open.
        e0 = dut_evts;
        press(0, 1, 0);
        check("s2_run_on", int'(tk.run), 1);
        press(0, 1, 0);
        check("s2_run_off", int'(tk.run), 0);
        check("s2_evts", dut_evts - e0, 2);

        // 3: pl_pa with gate closed, then close with run active.
        press(1, 0, 0);
        press(0, 1, 0);
        check("s3_run_closed", int'(tk.run), 0);
        check("s3_key_id", int'(tk.key_id), 2);
        press(1, 0, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        check("s3_gate", int'(tk.gate_open), 0);
        check("s3_run", int'(tk.run), 0);

        // 4: broken clear streaks do not fire; a full one pulses once.
        e0 = dut_evts; c0 = dut_clrs;
        hold(int'(DEB_N) - 1, 1, 0, 0, 1);
        hold(1, 1, 0, 0, 0);
        hold(int'(DEB_N) - 1, 1, 0, 0, 1);
        hold(2, 1, 0, 0, 0);
        check("s4_no_evt", dut_evts - e0, 0);
        press(0, 0, 1);
        check("s4_clr_width", dut_clrs - c0, 1);

        // 5: multi-hit ignored; gapped strobes still debounce.
        e0 = dut_evts;
        hold(10, 1, 1, 0, 1);
        check("s5_multi", dut_evts - e0, 0);
        for (int k = 0; k < int'(DEB_N); k++) begin
            hold(4, 0, 1, 0, 0);
            cycle(1, 1, 0, 0);
        end
        check("s5_gap_pre", dut_evts - e0, 0);
        cycle(0, 1, 0, 0);
        check("s5_gap_evt", dut_evts - e0, 1);
        hold(int'(REL_N), 1, 0, 0, 0);

        // 6: reset mid-debounce and mid-release.
        hold(int'(DEB_N) - 1, 1, 0, 1, 0);
        do_reset();
        e0 = dut_evts;
        press(1, 0, 0);
        check("s6_refire", dut_evts - e0, 1);
        hold(int'(DEB_N) + 1, 1, 1, 0, 0);
        hold(2, 1, 0, 0, 0);
        do_reset();
        hold(int'(DEB_N), 1, 0, 0, 1);
        hold(1, 1, 0, 0, 0);

        // Random bursts of held patterns, gapped strobes and occasional resets.
        for (int b = 0; b < 600; b++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            pat = $urandom_range(0, 9);
            o = (pat == 1) || (pat == 4) || (pat == 7);
            p = (pat == 2) || (pat == 5);
            c = (pat == 3) || (pat == 6) || (pat == 7);
            if (pat == 8) begin o = 1; p = 1; end
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                en = ($urandom_range(0, 3) != 0);
                cycle(en, o, p, c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
